// File: rtl/img_row_fetch_if.sv
`default_nettype none
// ============================================================
// img_row_fetch_if : start/SRAM-read/row-handshake bundle
// Rev 1.0
// ============================================================
interface img_row_fetch_if #(
  parameter int ROW = 28,
  parameter int DW  = 8,
  parameter int AW  = 10
);
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

  logic                start;
  logic [AW-1:0]       base_addr;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_rd_data;
  logic                row_valid;
  logic                row_ready;
  logic [ROW*DW-1:0]   row_data;
  logic [RW-1:0]       row_idx;
  logic                busy;
  logic                fetch_done;

  // Controller / SRAM / consumer side
  modport master (
    output start, base_addr, mem_rd_data, row_ready,
    input  mem_rd_en, mem_addr, row_valid, row_data, row_idx, busy, fetch_done
  );

  // Fetch engine side
  modport slave (
    input  start, base_addr, mem_rd_data, row_ready,
    output mem_rd_en, mem_addr, row_valid, row_data, row_idx, busy, fetch_done
  );
endinterface
`default_nettype wire

// File: rtl/img_row_fetch.sv
`default_nettype none
// ============================================================
// img_row_fetch : streams a ROWxROW image from SRAM row by row,
//                 double-buffered behind a valid/ready handshake
// Rev 1.0
// ============================================================
module img_row_fetch #(
  parameter int ROW = 28,
  parameter int DW  = 8,
  parameter int AW  = 10
) (
  input  logic           clk,
  input  logic           rst,
  img_row_fetch_if.slave bus
);
  localparam int              RW       = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [RW-1:0]   LAST_IDX = RW'(ROW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_PUSH  = 3'd3;
  localparam logic [2:0] S_LAST  = 3'd4;

  logic [2:0]        state_q,      state_d;
  logic [AW-1:0]     addr_q,       addr_d;
  logic [RW-1:0]     col_q,        col_d;
  logic [RW-1:0]     col_dly_q,    col_dly_d;
  logic              rd_pend_q,    rd_pend_d;
  logic [RW-1:0]     row_cnt_q,    row_cnt_d;
  logic [ROW*DW-1:0] fill_q,       fill_d;
  logic [ROW*DW-1:0] row_data_q,   row_data_d;
  logic [RW-1:0]     row_idx_q,    row_idx_d;
  logic              row_valid_q,  row_valid_d;
  logic              fetch_done_q, fetch_done_d;

  logic consume;
  logic push_xfer;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    col_d        = col_q;
    row_cnt_d    = row_cnt_q;
    fill_d       = fill_q;
    row_data_d   = row_data_q;
    row_idx_d    = row_idx_q;
    row_valid_d  = row_valid_q;
    fetch_done_d = 1'b0;

    // Read data lands one cycle after issue, tagged with the delayed column
    rd_pend_d = (state_q == S_FETCH);
    col_dly_d = col_q;

    consume   = row_valid_q & bus.row_ready;
    push_xfer = (state_q == S_PUSH) & (~row_valid_q | consume);

    if (rd_pend_q) begin
      fill_d[int'(col_dly_q) * DW +: DW] = bus.mem_rd_data;
    end

    if (consume) begin
      row_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d    = bus.base_addr;
          col_d     = '0;
          row_cnt_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        addr_d = addr_q + AW'(1);
        if (col_q == LAST_IDX) begin
          col_d   = '0;
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + RW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_PUSH;
      end
      S_PUSH: begin
        // A push in the same cycle as a consume keeps row_valid high
        if (push_xfer) begin
          row_data_d  = fill_q;
          row_idx_d   = row_cnt_q;
          row_valid_d = 1'b1;
          if (row_cnt_q == LAST_IDX) begin
            state_d = S_LAST;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_LAST: begin
        if (consume) begin
          fetch_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      col_q        <= '0;
      col_dly_q    <= '0;
      rd_pend_q    <= 1'b0;
      row_cnt_q    <= '0;
      fill_q       <= '0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
      row_valid_q  <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      col_q        <= col_d;
      col_dly_q    <= col_dly_d;
      rd_pend_q    <= rd_pend_d;
      row_cnt_q    <= row_cnt_d;
      fill_q       <= fill_d;
      row_data_q   <= row_data_d;
      row_idx_q    <= row_idx_d;
      row_valid_q  <= row_valid_d;
      fetch_done_q <= fetch_done_d;
    end
  end

  assign bus.mem_rd_en  = (state_q == S_FETCH);
  assign bus.mem_addr   = addr_q;
  assign bus.row_valid  = row_valid_q;
  assign bus.row_data   = row_data_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.busy       = (state_q != S_IDLE) | row_valid_q;
  assign bus.fetch_done = fetch_done_q;

endmodule
`default_nettype wire

// File: tb/tb_img_row_fetch.sv
`default_nettype none
// ============================================================
// tb_img_row_fetch : directed table-driven bench for img_row_fetch
// Rev 1.0
// ============================================================
module tb_img_row_fetch;
  localparam int ROW = 28;
  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int RW  = 5;

  typedef struct {
    logic [AW-1:0] base;
    int            ready_mode;   // 0: always ready, 1: ready on even cycles
    bit            noise;        // pulse start with junk base while busy
    int            exp_first;
    int            exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  img_row_fetch_if #(.ROW(ROW), .DW(DW), .AW(AW)) bus ();

  img_row_fetch #(.ROW(ROW), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: mem[a] = a[7:0], synchronous read
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
  end

  function automatic logic [ROW*DW-1:0] exp_row(input logic [AW-1:0] base, input int r);
    logic [ROW*DW-1:0] v;
    logic [AW-1:0]     a;
    v = '0;
    for (int c = 0; c < ROW; c++) begin
      a = base + AW'(r * ROW + c);
      v[c*DW +: DW] = a[7:0];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [ROW*DW-1:0] act, input logic [ROW*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, " rd_en"},      64'(bus.mem_rd_en),  0);
    chk({tag, " addr"},       64'(bus.mem_addr),   0);
    chk({tag, " row_valid"},  64'(bus.row_valid),  0);
    chk_row({tag, " row_data"}, bus.row_data, '0);
    chk({tag, " row_idx"},    64'(bus.row_idx),    0);
    chk({tag, " busy"},       64'(bus.busy),       0);
    chk({tag, " fetch_done"}, 64'(bus.fetch_done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Launch one image at the next falling edge (cycle k=0) and watch it to completion
  task automatic run_image(input vec_t v, input string tag);
    int k = 0, first = -1, done_k = -1, done_cnt = 0, rows = 0, reads = 0;
    int addr_err = 0, data_err = 0, idx_err = 0, stab_err = 0, busy_at_done = -1;
    logic [AW-1:0]     ea;
    logic              prev_hold;
    logic [ROW*DW-1:0] prev_data;
    logic [RW-1:0]     prev_idx;
    @(negedge clk);
    bus.base_addr = v.base;
    bus.start     = 1'b1;
    bus.row_ready = 1'b0;
    ea        = v.base;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_idx  = '0;
    while (k < 3000 && !(done_cnt > 0 && k >= done_k + 3)) begin
      @(negedge clk);
      k++;
      bus.start     = v.noise && (k % 7 == 1) && bus.busy;
      bus.base_addr = v.noise ? AW'(k * 37) : v.base;
      bus.row_ready = (v.ready_mode == 0) || (k % 2 == 0);
      if (bus.mem_rd_en) begin
        reads++;
        if (bus.mem_addr !== ea) addr_err++;
        ea = ea + AW'(1);
      end
      if (prev_hold && (!bus.row_valid || bus.row_data !== prev_data || bus.row_idx !== prev_idx))
        stab_err++;
      if (bus.row_valid && first < 0) first = k;
      if (bus.row_valid && bus.row_ready) begin
        if (bus.row_idx !== RW'(rows)) idx_err++;
        if (bus.row_data !== exp_row(v.base, rows)) data_err++;
        rows++;
      end
      prev_hold = bus.row_valid && !bus.row_ready;
      prev_data = bus.row_data;
      prev_idx  = bus.row_idx;
      if (bus.fetch_done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k       = k;
          busy_at_done = int'(bus.busy);
        end
      end
    end
    bus.start     = 1'b0;
    bus.row_ready = 1'b0;
    chk({tag, " first_valid_cycle"}, 64'(first),        64'(v.exp_first));
    chk({tag, " fetch_done_cycle"},  64'(done_k),       64'(v.exp_done));
    chk({tag, " fetch_done_count"},  64'(done_cnt),     1);
    chk({tag, " busy_at_done"},      64'(busy_at_done), 0);
    chk({tag, " rows"},              64'(rows),         ROW);
    chk({tag, " reads"},             64'(reads),        ROW * ROW);
    chk({tag, " addr_errors"},       64'(addr_err),     0);
    chk({tag, " data_errors"},       64'(data_err),     0);
    chk({tag, " idx_errors"},        64'(idx_err),      0);
    chk({tag, " stall_stability"},   64'(stab_err),     0);
    chk({tag, " busy_after"},        64'(bus.busy),     0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t post;
    int reads, addr_err, stab, drops;
    logic [AW-1:0] ea;

    vecs[0] = '{base: 10'd0,    ready_mode: 0, noise: 1'b0, exp_first: 31, exp_done: 842};
    vecs[1] = '{base: 10'd500,  ready_mode: 1, noise: 1'b0, exp_first: 31, exp_done: 843};
    vecs[2] = '{base: 10'd1000, ready_mode: 0, noise: 1'b0, exp_first: 31, exp_done: 842};
    vecs[3] = '{base: 10'd300,  ready_mode: 0, noise: 1'b1, exp_first: 31, exp_done: 842};
    post    = '{base: 10'd200,  ready_mode: 0, noise: 1'b0, exp_first: 31, exp_done: 842};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.row_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_check("por");

    for (int i = 0; i < 4; i++) begin
      run_image(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: consumer stalls 100 cycles on row 0
    @(negedge clk); bus.base_addr = 10'd0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("bp row0_valid", 64'(bus.row_valid), 1);
    reads = 0; addr_err = 0; stab = 0; ea = 10'd28;
    for (int j = 0; j < 100; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.mem_rd_en) begin
        reads++;
        if (bus.mem_addr !== ea) addr_err++;
        ea = ea + AW'(1);
      end
      if (!bus.row_valid || bus.row_idx !== '0 || bus.row_data !== exp_row(10'd0, 0)) stab++;
    end
    chk("bp reads", 64'(reads), 28);
    chk("bp addr_errors", 64'(addr_err), 0);
    chk("bp hold_errors", 64'(stab), 0);
    chk("bp rd_en_idle", 64'(bus.mem_rd_en), 0);
    @(negedge clk); bus.row_ready = 1'b1;
    chk("bp release_idx", 64'(bus.row_idx), 0);
    @(negedge clk); bus.row_ready = 1'b0;
    chk("bp row1_valid", 64'(bus.row_valid), 1);
    chk("bp row1_idx", 64'(bus.row_idx), 1);
    chk_row("bp row1_data", bus.row_data, exp_row(10'd0, 1));
    chk("bp row2_fetch_en", 64'(bus.mem_rd_en), 1);
    chk("bp row2_fetch_addr", 64'(bus.mem_addr), 56);
    reset_check("bp_reset");

    // Same-cycle transfer: ready only in the PUSH cycles (60, 90)
    @(negedge clk); bus.base_addr = 10'd0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (30) @(negedge clk);
    drops = 0;
    for (int kk = 31; kk <= 91; kk++) begin
      if (kk > 31) @(negedge clk);
      bus.row_ready = (kk == 60 || kk == 90);
      if (!bus.row_valid) drops++;
      if (kk == 60) chk("sc push_no_read", 64'(bus.mem_rd_en), 0);
      if (kk == 61) chk("sc idx1", 64'(bus.row_idx), 1);
      if (kk == 91) begin
        chk("sc idx2", 64'(bus.row_idx), 2);
        chk_row("sc row2_data", bus.row_data, exp_row(10'd0, 2));
      end
    end
    bus.row_ready = 1'b0;
    chk("sc bubbles", 64'(drops), 0);
    reset_check("sc_reset");

    // Reset mid-fetch at row 5 column 10, then a fresh image
    @(negedge clk); bus.base_addr = 10'd0; bus.start = 1'b1; bus.row_ready = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (160) @(negedge clk);
    chk("mf rd_en", 64'(bus.mem_rd_en), 1);
    chk("mf addr", 64'(bus.mem_addr), 150);
    reset_check("mf_reset");
    run_image(post, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/img_row_fetch.md
# img_row_fetch

Upstream feeder of the img2col mapping stage. Reads a ROW×ROW image of DW-bit pixels from a single-port synchronous-read image SRAM, one pixel per cycle. Assembles each image row in a fill buffer and double-buffers it into an output row register, which the mapping control consumes through a valid/ready handshake. Fetch of row r+1 overlaps with the mapping stage holding row r.

## Interface
Parameters:
- ROW, 28, pixels per row and rows per image
- DW, 8, pixel width
- AW, 10, SRAM address width (2^AW ≥ ROW*ROW)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin fetching one image; sampled only in IDLE
- base_addr  in  AW  address of pixel (0,0); latched on accepted start
- mem_rd_en  out  1  SRAM read strobe
- mem_addr  out  AW  SRAM read address
- mem_rd_data  in  DW  read data, valid exactly one cycle after mem_rd_en
- row_valid  out  1  row_data/row_idx hold a complete row
- row_ready  in  1  consumer accepts row this cycle
- row_data  out  ROW*DW  pixel c at bits [c*DW +: DW]
- row_idx  out  $clog2(ROW)  row number of row_data
- busy  out  1  state≠IDLE or row_valid
- fetch_done  out  1  one-cycle pulse after the last row is accepted

## Operation
- States: IDLE, FETCH, DRAIN, PUSH, LAST.
- IDLE:
  - start=1 latches base_addr into the address counter and clears the row counter → FETCH.
  - start is ignored in every other state.
- FETCH:
  - mem_rd_en=1, mem_addr=address counter; counter +1 per cycle, column counter 0..ROW-1.
  - Data returned one cycle later is written to fill_buf[col_d], where col_d is the column index delayed one cycle.
  - After column ROW-1 is issued → DRAIN.
- DRAIN: mem_rd_en=0; captures the final pixel → PUSH.
- PUSH: transfer is allowed when row_valid=0 or (row_valid & row_ready). On transfer:
  - row_data←fill_buf, row_idx←row counter, row_valid←1.
  - If row counter<ROW-1: increment it → FETCH.
  - Otherwise → LAST.
  - With no transfer, stay in PUSH with mem_rd_en=0.
- LAST: when row_valid & row_ready, clear row_valid, pulse fetch_done next cycle → IDLE.
- Handshake rules:
  - A row is consumed on any cycle with row_valid & row_ready. row_valid drops the next cycle unless a PUSH transfer occurs in the same cycle, in which case it stays 1 with the new row.
  - row_data and row_idx stay stable while row_valid=1 and row_ready=0.
- Address arithmetic: unsigned AW-bit, wraps modulo 2^AW. The address counter runs continuously across rows (row r, col c → base_addr+r*ROW+c). Wrap raises no error.
- Reset (any time, including mid-fetch):
  - state=IDLE, mem_rd_en=0, mem_addr=0, row_valid=0, row_data=0, row_idx=0, busy=0, fetch_done=0.
  - Fill buffer and counters cleared.
  - An in-flight read return is discarded.

## Timing
- start high in cycle T → mem_rd_en=1 in cycles T+1..T+ROW with mem_addr base..base+ROW-1.
- DRAIN in T+ROW+1; PUSH in T+ROW+2; row 0 row_valid=1 from T+ROW+3 (T+31 for ROW=28).
- Unstalled row period is ROW+2 cycles. FETCH of row r+1 starts the cycle after row r is transferred, regardless of consumer state.
- Stall behaviour: the fill buffer holds at most one pending row. With the output full and row_ready=0, the block waits in PUSH and issues no reads.
- fetch_done: the cycle after the handshake of row ROW-1. busy falls in the same cycle.

## Test plan
- **Full image, no backpressure:** SRAM mem[a]=a[7:0], base=0, row_ready=1, start at T.
  - First row_valid at T+31.
  - 28 rows; row r pixel c = (28r+c) mod 256, row_idx=r.
  - fetch_done asserted exactly once, busy=0 afterwards.
- **Backpressure:** row_ready=0 for 100 cycles after row 0 valid.
  - Exactly 28 reads for row 1, then mem_rd_en=0.
  - row_data/row_idx=0 stable throughout.
  - On release, row 1 is presented the cycle after row 0's handshake.
- **Same-cycle transfer:** row_ready asserted only in the cycle the block is in PUSH with row_valid=1.
  - row_valid stays 1 with no bubble; row_idx increments by 1.
- **Address wrap:** base_addr=1000, AW=10.
  - mem_addr sequence crosses 1023→0; row 0 pixel 24 read from address 0.
- **Start ignored while busy:** start pulses during FETCH, PUSH and LAST.
  - No change in address sequence or row count; one fetch_done.
- **Reset mid-fetch:** rst asserted during row 5, column 10.
  - All outputs read their reset values immediately.
  - A new start fetches from the new base_addr, beginning with row_idx=0.
